// File: rtl/tile_read_addr_gen.sv
// Read-side address sequencer: walks a rows x cols tile row-major, one address per valid/ready beat.
// Optional boustrophedon walk of odd rows when TILE_READ_SNAKE_EN is defined.
module tile_read_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  rows_i,
  input  logic [CNT_WIDTH-1:0]  cols_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
`ifdef TILE_READ_SNAKE_EN
  input  logic                  snake_i,
`endif
  input  logic                  addr_ready_i,
  output logic                  addr_valid_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  row_q, row_d, col_q, col_d;
  logic [CNT_WIDTH-1:0]  rows_q, rows_d, cols_q, cols_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d, stride_q, stride_d;
  logic                  snake_q, snake_d, snake_in;
  logic [CNT_WIDTH-1:0]  row_end_col, next_row, d_end_col;
  logic                  valid_d, last_d, busy_d, done_d;
  logic [ADDR_WIDTH-1:0] addr_d;

`ifdef TILE_READ_SNAKE_EN
  assign snake_in = snake_i;
`else
  assign snake_in = 1'b0;
`endif

  // Next-state and counter update; outputs are precomputed from the next state so they leave flops.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    row_base_d = row_base_q;
    stride_d   = stride_q;
    snake_d    = snake_q;
    row_end_col = (snake_q && row_q[0]) ? '0 : cols_q;
    next_row    = row_q + CNT_WIDTH'(1);

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          rows_d     = rows_i;
          cols_d     = cols_i;
          stride_d   = stride_i;
          snake_d    = snake_in;
          row_d      = '0;
          col_d      = '0;
          row_base_d = base_addr_i;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (addr_ready_i) begin
          if (col_q == row_end_col) begin
            if (row_q == rows_q) begin
              state_d = DONE;
            end else begin
              row_d      = next_row;
              row_base_d = row_base_q + stride_q;
              col_d      = (snake_q && next_row[0]) ? cols_q : '0;
            end
          end else begin
            col_d = (snake_q && row_q[0]) ? col_q - CNT_WIDTH'(1) : col_q + CNT_WIDTH'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort wins over start and over a beat in the same cycle.
    if (clear_i) begin
      state_d    = IDLE;
      row_d      = '0;
      col_d      = '0;
      row_base_d = '0;
    end

    d_end_col = (snake_d && row_d[0]) ? '0 : cols_d;
    valid_d   = (state_d == RUN);
    addr_d    = valid_d ? row_base_d + ADDR_WIDTH'(col_d) : '0;
    last_d    = valid_d && (row_d == rows_d) && (col_d == d_end_col);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      row_base_q   <= '0;
      stride_q     <= '0;
      snake_q      <= 1'b0;
      addr_valid_o <= 1'b0;
      addr_o       <= '0;
      last_o       <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      row_base_q   <= row_base_d;
      stride_q     <= stride_d;
      snake_q      <= snake_d;
      addr_valid_o <= valid_d;
      addr_o       <= addr_d;
      last_o       <= last_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
    end
  end

endmodule

// File: tb/tb_tile_read_addr_gen.sv
// Directed bench for tile_read_addr_gen with hand-computed address sequences.
module tb_tile_read_addr_gen;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       clear_i;
  logic       start_i;
  logic [3:0] rows_i;
  logic [3:0] cols_i;
  logic [7:0] base_addr_i;
  logic [7:0] stride_i;
`ifdef TILE_READ_SNAKE_EN
  logic       snake_i;
`endif
  logic       addr_ready_i;
  logic       addr_valid_o;
  logic [7:0] addr_o;
  logic       last_o;
  logic       busy_o;
  logic       done_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  tile_read_addr_gen #(.ADDR_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .start_i      (start_i),
    .rows_i       (rows_i),
    .cols_i       (cols_i),
    .base_addr_i  (base_addr_i),
    .stride_i     (stride_i),
`ifdef TILE_READ_SNAKE_EN
    .snake_i      (snake_i),
`endif
    .addr_ready_i (addr_ready_i),
    .addr_valid_o (addr_valid_o),
    .addr_o       (addr_o),
    .last_o       (last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(addr_valid_o), 32'd0);
    check({tag, "_addr"},  32'(addr_o),       32'd0);
    check({tag, "_last"},  32'(last_o),       32'd0);
    check({tag, "_busy"},  32'(busy_o),       32'd0);
    check({tag, "_done"},  32'(done_o),       32'd0);
  endtask

  // Start a walk and check each beat against exp_q; ready_mode 1 gives ready pattern 1,0,0,1,0,0...
  // inject_at >= 0 pulses start with a different config during RUN at that cycle.
  task automatic walk(input logic [3:0] rows, input logic [3:0] cols, input logic [7:0] base,
                      input logic [7:0] stride, input int ready_mode, input int inject_at);
    int   idx;
    int   cyc;
    logic rdy;
    @(negedge clk_i);
    start_i = 1'b1; rows_i = rows; cols_i = cols; base_addr_i = base; stride_i = stride;
    addr_ready_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < exp_q.size() && cyc < 100) begin
      check("beat_valid", 32'(addr_valid_o), 32'd1);
      check("beat_addr",  32'(addr_o),       32'(exp_q[idx]));
      check("beat_last",  32'(last_o),       32'(idx == exp_q.size() - 1));
      check("beat_busy",  32'(busy_o),       32'd1);
      check("beat_done",  32'(done_o),       32'd0);
      rdy = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      addr_ready_i = rdy;
      if (cyc == inject_at) begin
        start_i = 1'b1; rows_i = 4'd0; cols_i = 4'd0; base_addr_i = 8'h80; stride_i = 8'h40;
      end else begin
        start_i = 1'b0;
      end
      if (rdy) idx++;
      @(negedge clk_i);
      cyc++;
    end
    start_i = 1'b0;
    check("walk_bound",  32'(cyc < 100),    32'd1);
    check("done_pulse",  32'(done_o),       32'd1);
    check("done_valid",  32'(addr_valid_o), 32'd0);
    check("done_busy",   32'(busy_o),       32'd1);
    @(negedge clk_i);
    check("post_done",   32'(done_o),       32'd0);
    check("post_busy",   32'(busy_o),       32'd0);
    check("post_valid",  32'(addr_valid_o), 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; rows_i = '0; cols_i = '0;
    base_addr_i = '0; stride_i = '0; addr_ready_i = 1'b0;
`ifdef TILE_READ_SNAKE_EN
    snake_i = 1'b0;
`endif
    #12;
    check_idle("rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_idle("idle");

    // Basic 2x3 tile, full throughput
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h18, 8'h19, 8'h1A};
    walk(4'd1, 4'd2, 8'h10, 8'h08, 0, -1);

    // Same tile under back-pressure
    walk(4'd1, 4'd2, 8'h10, 8'h08, 1, -1);

    // Single-beat tile
    exp_q = '{8'hFF};
    walk(4'd0, 4'd0, 8'hFF, 8'h08, 0, -1);

    // Row-base wraps modulo 256
    exp_q = '{8'hF8, 8'h00, 8'h08};
    walk(4'd2, 4'd0, 8'hF8, 8'h08, 0, -1);

    // Start pulse with new config during RUN is ignored
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h18, 8'h19, 8'h1A};
    walk(4'd1, 4'd2, 8'h10, 8'h08, 0, 1);

    // Clear during third beat aborts without done
    @(negedge clk_i);
    start_i = 1'b1; rows_i = 4'd1; cols_i = 4'd2; base_addr_i = 8'h10; stride_i = 8'h08;
    addr_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("clr_b0", 32'(addr_o), 32'h10);
    @(negedge clk_i);
    check("clr_b1", 32'(addr_o), 32'h11);
    @(negedge clk_i);
    check("clr_b2", 32'(addr_o), 32'h12);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    check_idle("clr");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("clr_nodone", 32'(done_o), 32'd0);
    end
    exp_q = '{8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32};
    walk(4'd1, 4'd2, 8'h20, 8'h10, 0, -1);

    // Asynchronous reset mid-walk
    @(negedge clk_i);
    start_i = 1'b1; rows_i = 4'd1; cols_i = 4'd2; base_addr_i = 8'h40; stride_i = 8'h08;
    addr_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    check("rst_mid_addr", 32'(addr_o), 32'h41);
    #2 rst_ni = 1'b0;
    #1 check_idle("arst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_idle("arst_rel");
    exp_q = '{8'h40, 8'h41, 8'h42, 8'h48, 8'h49, 8'h4A};
    walk(4'd1, 4'd2, 8'h40, 8'h08, 0, -1);

`ifdef TILE_READ_SNAKE_EN
    snake_i = 1'b1;
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h0A, 8'h09, 8'h08};
    walk(4'd1, 4'd2, 8'h00, 8'h08, 0, -1);
    snake_i = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
